// File: rtl/md5_job_scheduler.sv
// Round-robin scheduler sharing one MD5 core among N guess generators; compares digests to a target and halts on a hit.
// Overhead: 3 cycles per candidate plus core latency. req_ready follows core_ready for the granted requester only.
module md5_job_scheduler #(
    parameter int N       = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              stop,
    input  logic [127:0]      target_hash,
    input  logic [N-1:0]      req_valid,
    input  logic [N*128-1:0]  req_word,
    input  logic [N*8-1:0]    req_width,
    output logic [N-1:0]      req_ready,
    input  logic              core_ready,
    output logic [127:0]      core_msg,
    output logic [7:0]        core_msg_width,
    output logic              core_msg_valid,
    input  logic [127:0]      core_digest,
    input  logic              core_digest_valid,
    output logic              busy,
    output logic              found,
    output logic [127:0]      found_word,
    output logic [2:0]        found_id,
    output logic              timeout_err,
    output logic [31:0]       hash_count
);

    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [2:0] LAST_INIT = 3'(N - 1);

    typedef enum logic [2:0] {IDLE, ARB, ISSUE, WAIT, FOUND} state_t;

    state_t        state_q, state_d;
    logic [2:0]    grant_q, grant_d;
    logic [2:0]    last_grant_q, last_grant_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [127:0]  core_msg_q, core_msg_d;
    logic [7:0]    core_msg_width_q, core_msg_width_d;
    logic          core_msg_valid_q, core_msg_valid_d;
    logic          found_q, found_d;
    logic [127:0]  found_word_q, found_word_d;
    logic [2:0]    found_id_q, found_id_d;
    logic          timeout_err_q, timeout_err_d;
    logic [31:0]   hash_count_q, hash_count_d;

    logic [N-1:0]  grant_oh;
    logic          sel_valid;
    logic [127:0]  sel_word;
    logic [7:0]    sel_width;
    logic [2:0]    arb_idx, lo_idx, hi_idx;
    logic          hi_hit;

    // Round-robin pick: lowest valid index above last_grant, else lowest valid overall.
    always_comb begin
        lo_idx = '0;
        hi_idx = '0;
        hi_hit = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req_valid[i]) begin
                lo_idx = 3'(i);
                if (3'(i) > last_grant_q) begin
                    hi_idx = 3'(i);
                    hi_hit = 1'b1;
                end
            end
        end
        arb_idx = hi_hit ? hi_idx : lo_idx;
    end

    always_comb begin
        grant_oh  = N'(1) << grant_q;
        sel_valid = |(req_valid & grant_oh);
        sel_word  = '0;
        sel_width = '0;
        for (int i = 0; i < N; i++) begin
            if (grant_q == 3'(i)) begin
                sel_word  = req_word[i*128 +: 128];
                sel_width = req_width[i*8 +: 8];
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        grant_d          = grant_q;
        last_grant_d     = last_grant_q;
        timer_d          = timer_q;
        core_msg_d       = core_msg_q;
        core_msg_width_d = core_msg_width_q;
        core_msg_valid_d = 1'b0;
        found_d          = found_q;
        found_word_d     = found_word_q;
        found_id_d       = found_id_q;
        timeout_err_d    = timeout_err_q;
        hash_count_d     = hash_count_q;

        if (stop) begin
            // Results are kept; a digest landing this cycle is dropped uncounted.
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, FOUND: begin
                    if (start) begin
                        found_d       = 1'b0;
                        found_word_d  = '0;
                        found_id_d    = '0;
                        timeout_err_d = 1'b0;
                        hash_count_d  = '0;
                        last_grant_d  = LAST_INIT;
                        state_d       = ARB;
                    end
                end
                ARB: begin
                    if (|req_valid) begin
                        grant_d = arb_idx;
                        state_d = ISSUE;
                    end
                end
                ISSUE: begin
                    if (sel_valid && core_ready) begin
                        core_msg_d       = sel_word;
                        core_msg_width_d = sel_width;
                        core_msg_valid_d = 1'b1;
                        timer_d          = '0;
                        state_d          = WAIT;
                    end else if (!sel_valid) begin
                        state_d = ARB;
                    end
                end
                WAIT: begin
                    if (core_digest_valid) begin
                        if (hash_count_q != '1) begin
                            hash_count_d = hash_count_q + 32'd1;
                        end
                        last_grant_d = grant_q;
                        if (core_digest == target_hash) begin
                            found_d      = 1'b1;
                            found_word_d = core_msg_q;
                            found_id_d   = grant_q;
                            state_d      = FOUND;
                        end else begin
                            state_d = ARB;
                        end
                    end else if (timer_q == TW'(TIMEOUT)) begin
                        timeout_err_d = 1'b1;
                        state_d       = IDLE;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q          <= IDLE;
            grant_q          <= '0;
            last_grant_q     <= LAST_INIT;
            timer_q          <= '0;
            core_msg_q       <= '0;
            core_msg_width_q <= '0;
            core_msg_valid_q <= 1'b0;
            found_q          <= 1'b0;
            found_word_q     <= '0;
            found_id_q       <= '0;
            timeout_err_q    <= 1'b0;
            hash_count_q     <= '0;
        end else begin
            state_q          <= state_d;
            grant_q          <= grant_d;
            last_grant_q     <= last_grant_d;
            timer_q          <= timer_d;
            core_msg_q       <= core_msg_d;
            core_msg_width_q <= core_msg_width_d;
            core_msg_valid_q <= core_msg_valid_d;
            found_q          <= found_d;
            found_word_q     <= found_word_d;
            found_id_q       <= found_id_d;
            timeout_err_q    <= timeout_err_d;
            hash_count_q     <= hash_count_d;
        end
    end

    // Ready is masked during stop so an aborted ISSUE never looks like an accepted job.
    assign req_ready      = (state_q == ISSUE && core_ready && !stop) ? grant_oh : '0;
    assign busy           = (state_q == ARB) || (state_q == ISSUE) || (state_q == WAIT);
    assign core_msg       = core_msg_q;
    assign core_msg_width = core_msg_width_q;
    assign core_msg_valid = core_msg_valid_q;
    assign found          = found_q;
    assign found_word     = found_word_q;
    assign found_id       = found_id_q;
    assign timeout_err    = timeout_err_q;
    assign hash_count     = hash_count_q;

endmodule
